key_led_ctrl: RTL and testbench



---
 rtl/key_led_pkg.sv | 36 +++
 rtl/key_debounce.sv | 137 +++++++++++++
 rtl/key_led_ctrl.sv | 58 +++++
 tb/tb_key_led_ctrl.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/key_led_pkg.sv
// Shared types and defaults for the key conditioning / LED pattern block.
package key_led_pkg;

  localparam int unsigned NUM_KEYS            = 2;
  localparam int unsigned LED_W               = 8;
  localparam int unsigned DEF_DB_CYCLES       = 1_000_000;
  localparam int unsigned DEF_LONG_CYCLES     = 50_000_000;
  localparam logic [LED_W-1:0] DEF_LED_INIT   = 8'h01;

  typedef enum logic [1:0] {
    KS_RELEASED     = 2'd0,
    KS_PRESS_WAIT   = 2'd1,
    KS_PRESSED      = 2'd2,
    KS_RELEASE_WAIT = 2'd3
  } key_state_e;

  // Next LED pattern: long KEY1 clears, KEY0 press increments, KEY1 press rotates.
  function automatic logic [LED_W-1:0] led_next(
    input logic [LED_W-1:0] led,
    input logic             inc,
    input logic             rot,
    input logic             clr
  );
    logic [LED_W-1:0] res;
    res = led;
    if (clr) begin
      res = '0;
    end else if (inc) begin
      res = led + LED_W'(1);
    end else if (rot) begin
      res = {led[LED_W-2:0], led[LED_W-1]};
    end
    return res;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One key: 2-FF synchroniser, debounce FSM and hold counter with press/release/long pulses.
module key_debounce
  import key_led_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,      // raw, active-low, asynchronous
  output logic state_o,    // debounced level, 1 = pressed
  output logic press_o,
  output logic release_o,
  output logic long_o
);

  localparam int unsigned CNT_W  = $clog2(DB_CYCLES + 1);
  localparam int unsigned HCNT_W = $clog2(LONG_CYCLES + 1);
  // The synchroniser capture and the first FSM sample already account for two
  // of the window, so the wait states terminate two counts early.
  localparam int unsigned DB_LAST = (DB_CYCLES >= 2) ? (DB_CYCLES - 2) : 0;

  logic              key_meta_q, key_sync_q;
  key_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic              level_q, level_d;
  logic              press_q, press_d;
  logic              release_q, release_d;
  logic              long_q, long_d;

  // Two-stage synchroniser, idles released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_meta_q <= 1'b1;
      key_sync_q <= 1'b1;
    end else begin
      key_meta_q <= key_i;
      key_sync_q <= key_meta_q;
    end
  end

  // FSM, counters and registered event outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= KS_RELEASED;
      cnt_q     <= '0;
      hcnt_q    <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hcnt_q    <= hcnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  // Next-state, counter and pulse decode.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hcnt_d    = hcnt_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;
    unique case (state_q)
      KS_RELEASED: begin
        if (!key_sync_q) begin
          cnt_d = '0;
          if (DB_CYCLES == 1) begin
            state_d = KS_PRESSED;
            press_d = 1'b1;
          end else begin
            state_d = KS_PRESS_WAIT;
          end
        end
      end
      KS_PRESS_WAIT: begin
        if (key_sync_q) begin
          state_d = KS_RELEASED;
        end else if (cnt_q == CNT_W'(DB_LAST)) begin
          state_d = KS_PRESSED;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      KS_PRESSED: begin
        // Saturating hold count; the single long pulse fires on the final step.
        if (hcnt_q != HCNT_W'(LONG_CYCLES)) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
          if (hcnt_q == HCNT_W'(LONG_CYCLES - 1)) begin
            long_d = 1'b1;
          end
        end
        if (key_sync_q) begin
          cnt_d = '0;
          if (DB_CYCLES == 1) begin
            state_d   = KS_RELEASED;
            release_d = 1'b1;
            hcnt_d    = '0;
          end else begin
            state_d = KS_RELEASE_WAIT;
          end
        end
      end
      KS_RELEASE_WAIT: begin
        // A bounce back to low resumes the hold with hcnt untouched.
        if (!key_sync_q) begin
          state_d = KS_PRESSED;
        end else if (cnt_q == CNT_W'(DB_LAST)) begin
          state_d   = KS_RELEASED;
          release_d = 1'b1;
          hcnt_d    = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = KS_RELEASED;
      end
    endcase
    level_d = (state_d == KS_PRESSED) || (state_d == KS_RELEASE_WAIT);
  end

  assign state_o   = level_q;
  assign press_o   = press_q;
  assign release_o = release_q;
  assign long_o    = long_q;

endmodule

// File: rtl/key_led_ctrl.sv
// Debounces the two board keys and drives the LED pattern register from their events.
module key_led_ctrl
  import key_led_pkg::*;
#(
  parameter int unsigned DB_CYCLES   = DEF_DB_CYCLES,
  parameter int unsigned LONG_CYCLES = DEF_LONG_CYCLES,
  parameter logic [7:0]  LED_INIT    = DEF_LED_INIT
) (
  input  logic       CLOCK_50,
  input  logic       RESET_N,
  input  logic [1:0] KEY,
  output logic [7:0] LED,
  output logic [1:0] KEY_STATE,
  output logic [1:0] KEY_PRESS,
  output logic [1:0] KEY_RELEASE,
  output logic [1:0] KEY_LONG
);

  logic [NUM_KEYS-1:0] key_state, key_press, key_release, key_long;
  logic [LED_W-1:0]    led_q, led_d;

  for (genvar g = 0; g < NUM_KEYS; g++) begin : g_key
    key_debounce #(
      .DB_CYCLES  (DB_CYCLES),
      .LONG_CYCLES(LONG_CYCLES)
    ) u_key_debounce (
      .clk      (CLOCK_50),
      .rst_n    (RESET_N),
      .key_i    (KEY[g]),
      .state_o  (key_state[g]),
      .press_o  (key_press[g]),
      .release_o(key_release[g]),
      .long_o   (key_long[g])
    );
  end

  // LED pattern update; a rotate coinciding with an increment is dropped.
  always_comb begin
    led_d = led_q;
    led_d = led_next(led_q, key_press[0], key_press[1], key_long[1]);
  end

  // LED pattern register.
  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
      led_q <= LED_INIT;
    end else begin
      led_q <= led_d;
    end
  end

  assign LED         = led_q;
  assign KEY_STATE   = key_state;
  assign KEY_PRESS   = key_press;
  assign KEY_RELEASE = key_release;
  assign KEY_LONG    = key_long;

endmodule

// File: tb/tb_key_led_ctrl.sv
// Scoreboard bench for key_led_ctrl with a run-length reference model of the keys.
module tb_key_led_ctrl;

  localparam int DB   = 4;
  localparam int LONG = 20;
  localparam logic [7:0] INIT = 8'h01;

  logic       CLOCK_50 = 1'b0;
  logic       RESET_N  = 1'b0;
  logic [1:0] KEY      = 2'b11;
  logic [7:0] LED;
  logic [1:0] KEY_STATE, KEY_PRESS, KEY_RELEASE, KEY_LONG;

  key_led_ctrl #(
    .DB_CYCLES  (DB),
    .LONG_CYCLES(LONG),
    .LED_INIT   (INIT)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET_N    (RESET_N),
    .KEY        (KEY),
    .LED        (LED),
    .KEY_STATE  (KEY_STATE),
    .KEY_PRESS  (KEY_PRESS),
    .KEY_RELEASE(KEY_RELEASE),
    .KEY_LONG   (KEY_LONG)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  typedef struct {
    int         cyc;
    logic [1:0] prs;
    logic [1:0] rel;
    logic [1:0] lng;
    logic [1:0] st;
    logic [7:0] led;
  } ev_t;

  ev_t sb_q[$];
  int  n_tests = 0;
  int  n_fail  = 0;
  int  cyc     = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a key flips its debounced level once DB consecutive raw
  // samples disagree with it; events appear two edges after the deciding sample.
  logic [1:0] m_deb;
  int         m_run [2];
  int         m_hold[2];
  logic [7:0] m_led;

  always @(posedge CLOCK_50) begin
    ev_t        e;
    logic [1:0] pressed;
    logic       held;
    cyc++;
    if (!RESET_N) begin
      m_deb = 2'b00;
      for (int k = 0; k < 2; k++) begin
        m_run[k]  = 0;
        m_hold[k] = 0;
      end
      m_led = INIT;
    end else begin
      pressed = ~KEY;
      e.prs = 2'b00; e.rel = 2'b00; e.lng = 2'b00;
      for (int k = 0; k < 2; k++) begin
        held = m_deb[k] && (m_run[k] == 0);
        if (pressed[k] != m_deb[k]) m_run[k]++;
        else m_run[k] = 0;
        if (m_run[k] == DB) begin
          m_deb[k] = pressed[k];
          m_run[k] = 0;
          if (pressed[k]) e.prs[k] = 1'b1;
          else e.rel[k] = 1'b1;
        end
        if (held && m_hold[k] < LONG) begin
          m_hold[k]++;
          if (m_hold[k] == LONG) e.lng[k] = 1'b1;
        end
        if (e.rel[k]) m_hold[k] = 0;
      end
      if (|{e.prs, e.rel, e.lng}) begin
        if (e.lng[1]) m_led = 8'h00;
        else if (e.prs[0]) m_led = m_led + 8'd1;
        else if (e.prs[1]) m_led = {m_led[6:0], m_led[7]};
        e.led = m_led;
        e.st  = m_deb;
        e.cyc = cyc + 2;
        sb_q.push_back(e);
      end
    end
  end

  // Monitor: pops an expected event whenever the DUT pulses, checks LED a cycle later.
  logic       pend;
  logic [7:0] pend_led, last_led;
  logic [1:0] last_st;

  always @(negedge CLOCK_50) begin
    ev_t e;
    if (!RESET_N) begin
      pend     = 1'b0;
      last_led = INIT;
      last_st  = 2'b00;
    end else begin
      if (pend) begin
        chk("led_update", LED, pend_led);
        last_led = pend_led;
        pend     = 1'b0;
      end else if (LED !== last_led) begin
        chk("led_unexpected_change", LED, last_led);
        last_led = LED;
      end
      if (|{KEY_PRESS, KEY_RELEASE, KEY_LONG}) begin
        if (sb_q.size() == 0) begin
          chk("spurious_pulse", {KEY_PRESS, KEY_RELEASE, KEY_LONG}, 0);
        end else begin
          e = sb_q.pop_front();
          chk("pulse_cycle", e.cyc == cyc ? 1 : cyc, e.cyc == cyc ? 1 : e.cyc);
          chk("key_press", KEY_PRESS, e.prs);
          chk("key_release", KEY_RELEASE, e.rel);
          chk("key_long", KEY_LONG, e.lng);
          chk("key_state", KEY_STATE, e.st);
          pend     = 1'b1;
          pend_led = e.led;
          last_st  = e.st;
        end
      end else if (KEY_STATE !== last_st) begin
        chk("key_state_unexpected", KEY_STATE, last_st);
        last_st = KEY_STATE;
      end
      if (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
        chk("missed_event_at", cyc, sb_q[0].cyc);
        void'(sb_q.pop_front());
      end
    end
  end

  // Hold pressed levels (1 = pressed) for n cycles, starting at a falling edge.
  task automatic drive(input logic [1:0] pressed, input int n);
    KEY = ~pressed;
    repeat (n) @(negedge CLOCK_50);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_led"}, LED, INIT);
    chk({tag, "_state"}, KEY_STATE, 2'b00);
    chk({tag, "_press"}, KEY_PRESS, 2'b00);
    chk({tag, "_release"}, KEY_RELEASE, 2'b00);
    chk({tag, "_long"}, KEY_LONG, 2'b00);
  endtask

  // Asynchronous reset asserted mid-cycle, released on a falling edge.
  task automatic async_reset(input string tag);
    @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs(tag);
    sb_q.delete();
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
  endtask

  initial begin
    KEY     = 2'b11;
    RESET_N = 1'b0;
    repeat (3) @(negedge CLOCK_50);
    check_reset_outputs("rst_init");
    RESET_N = 1'b1;
    drive(2'b00, 5);

    // Clean KEY0 press and release.
    drive(2'b01, 12);
    drive(2'b00, 12);
    chk("led_after_clean_press", LED, 8'h02);

    // Bounce rejection, then a real press.
    repeat (10) begin
      drive(2'b01, 3);
      drive(2'b00, 1);
    end
    drive(2'b00, 4);
    chk("led_after_bounce", LED, 8'h02);
    drive(2'b01, 12);
    drive(2'b00, 12);
    chk("led_after_bounce_press", LED, 8'h03);

    // Long press on KEY1, then a hold with a short release-side bounce.
    async_reset("rst_long");
    drive(2'b00, 4);
    drive(2'b10, 40);
    drive(2'b00, 12);
    chk("led_after_long", LED, 8'h00);
    drive(2'b10, 30);
    drive(2'b00, 2);
    drive(2'b10, 10);
    drive(2'b00, 12);
    chk("led_after_bounced_long", LED, 8'h00);

    // Simultaneous press: rotate dropped in favour of increment.
    async_reset("rst_simul");
    drive(2'b00, 4);
    drive(2'b11, 10);
    drive(2'b00, 12);
    chk("led_after_simul", LED, 8'h02);

    // Increment up to 8'hFF and wrap.
    repeat (253) begin
      drive(2'b01, 6);
      drive(2'b00, 6);
    end
    chk("led_preload_ff", LED, 8'hFF);
    drive(2'b01, 6);
    drive(2'b00, 8);
    chk("led_wrap", LED, 8'h00);

    // Randomized key activity against the model.
    repeat (150) drive(2'($urandom_range(0, 3)), int'($urandom_range(1, 30)));
    drive(2'b00, 30);

    // Reset while KEY0 is mid-debounce, key still held afterwards.
    async_reset("rst_pre_db");
    drive(2'b00, 4);
    KEY = 2'b10;
    repeat (3) @(posedge CLOCK_50);
    #2 RESET_N = 1'b0;
    #1 check_reset_outputs("rst_mid_db");
    sb_q.delete();
    repeat (3) @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (15) @(negedge CLOCK_50);
    chk("led_after_rst_press", LED, 8'h02);
    chk("state_after_rst_press", KEY_STATE, 2'b01);
    drive(2'b00, 20);

    chk("scoreboard_drained", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
